// File: rtl/gamepad_pkg.sv
// Shared constants for the serial gamepad front end: FSM encoding, button indices
// and the width helper used to size counters.
package gamepad_pkg;

  typedef logic [2:0] gp_state_t;

  localparam gp_state_t ST_IDLE   = 3'd0;
  localparam gp_state_t ST_LATCH  = 3'd1;
  localparam gp_state_t ST_CLK_LO = 3'd2;
  localparam gp_state_t ST_CLK_HI = 3'd3;
  localparam gp_state_t ST_DONE   = 3'd4;

  // NES order; SNES pads extend the same stream past bit 7.
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned BTN_SNES_X = 9;
  localparam int unsigned BTN_SNES_L = 10;
  localparam int unsigned BTN_SNES_R = 11;

  function automatic int unsigned gp_clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/pad_shift_chan.sv
// One controller channel: LSB-first shift register, inversion to active-high and
// newly-pressed edge detection, all published on the load strobe.
module pad_shift_chan
  import gamepad_pkg::*;
#(
  parameter int unsigned N_BITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_i,
  input  logic              load_i,
  input  logic              data_i,
  output logic [N_BITS-1:0] buttons_o,
  output logic [N_BITS-1:0] pressed_o
);

  logic [N_BITS-1:0] shift_q, shift_d, shift_in;
  logic [N_BITS-1:0] buttons_q, buttons_d;
  logic [N_BITS-1:0] pressed_q, pressed_d;

  // New bits enter at the top so the first bit received ends up in bit 0.
  if (N_BITS == 1) begin : g_one
    assign shift_in = data_i;
  end else begin : g_multi
    assign shift_in = {data_i, shift_q[N_BITS-1:1]};
  end

  always_comb begin
    shift_d   = sample_i ? shift_in : shift_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    // The final bit is sampled on the same edge as the load, so publish from shift_d.
    if (load_i) begin
      buttons_d = ~shift_d;
      pressed_d = buttons_d & ~buttons_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      buttons_q <= '0;
      pressed_q <= '0;
    end else begin
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      pressed_q <= pressed_d;
    end
  end

  assign buttons_o = buttons_q;
  assign pressed_o = pressed_q;

endmodule

// File: rtl/gamepad_reader.sv
// Polls 1-4 NES/SNES shift-register pads over shared latch/clock pins and presents
// registered active-high button vectors with a per-poll valid strobe.
module gamepad_reader
  import gamepad_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned N_BITS      = 8,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned POLL_PERIOD = 420000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          poll_req,
  input  logic [N_PLAYERS-1:0]          pad_data,
  output logic                          pad_latch,
  output logic                          pad_clk,
  output logic [N_PLAYERS*N_BITS-1:0]   buttons,
  output logic [N_PLAYERS*N_BITS-1:0]   pressed,
  output logic                          buttons_valid,
  output logic                          busy
);

  localparam int unsigned PW = gp_clog2(2 * CLK_DIV);
  localparam int unsigned BW = gp_clog2(N_BITS) + 1;
  localparam int unsigned CW = gp_clog2(POLL_PERIOD);

  localparam logic [PW-1:0] PH_LATCH_END = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF_END  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(N_BITS - 1);
  localparam logic [CW-1:0] POLL_LAST    = CW'(POLL_PERIOD - 1);

  gp_state_t     state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [CW-1:0] poll_cnt_q, poll_cnt_d;
  logic          pad_latch_q, pad_latch_d;
  logic          pad_clk_q, pad_clk_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          start;
  logic          sample;
  logic          load;

  always_comb begin
    poll_cnt_d = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + 1'b1;
  end

  // Requests seen outside IDLE are simply dropped.
  assign start = (state_q == ST_IDLE) && (poll_req || (ena && (poll_cnt_q == POLL_LAST)));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    sample    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d   = '0;
        bit_idx_d = '0;
        if (start) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (phase_q == PH_LATCH_END) begin
          sample    = 1'b1;
          phase_d   = '0;
          bit_idx_d = BW'(1);
          state_d   = (N_BITS == 1) ? ST_DONE : ST_CLK_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (phase_q == PH_HALF_END) begin
          phase_d = '0;
          state_d = ST_CLK_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (phase_q == PH_HALF_END) begin
          sample  = 1'b1;
          phase_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_CLK_LO;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        bit_idx_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        phase_d   = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Pin and status registers follow the next state so they line up with state_q.
  always_comb begin
    load        = (state_d == ST_DONE);
    pad_latch_d = (state_d == ST_LATCH);
    pad_clk_d   = (state_d != ST_CLK_LO);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      poll_cnt_q  <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      poll_cnt_q  <= poll_cnt_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_chan
    pad_shift_chan #(
      .N_BITS(N_BITS)
    ) u_chan (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .sample_i (sample),
      .load_i   (load),
      .data_i   (pad_data[p]),
      .buttons_o(buttons[p*N_BITS +: N_BITS]),
      .pressed_o(pressed[p*N_BITS +: N_BITS])
    );
  end

  assign pad_latch     = pad_latch_q;
  assign pad_clk       = pad_clk_q;
  assign busy          = busy_q;
  assign buttons_valid = valid_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader: a 2x8 NES instance and a 1x12 SNES instance
// driven by behavioural shift-register pad models.
module tb_gamepad_reader;
  import gamepad_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ena, poll_req, pad_override;
  logic [1:0]  pad_data;
  logic        pad_latch, pad_clk, buttons_valid, busy;
  logic [15:0] buttons, pressed;

  logic        poll_req_s;
  logic [0:0]  pad_data_s;
  logic        pad_latch_s, pad_clk_s, buttons_valid_s, busy_s;
  logic [11:0] buttons_s, pressed_s;

  gamepad_reader #(
    .N_PLAYERS(2), .N_BITS(8), .CLK_DIV(2), .POLL_PERIOD(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .poll_req(poll_req), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons), .pressed(pressed),
    .buttons_valid(buttons_valid), .busy(busy)
  );

  gamepad_reader #(
    .N_PLAYERS(1), .N_BITS(12), .CLK_DIV(2), .POLL_PERIOD(64)
  ) dut_snes (
    .clk(clk), .rst_n(rst_n), .ena(1'b0), .poll_req(poll_req_s), .pad_data(pad_data_s),
    .pad_latch(pad_latch_s), .pad_clk(pad_clk_s), .buttons(buttons_s), .pressed(pressed_s),
    .buttons_valid(buttons_valid_s), .busy(busy_s)
  );

  // Pad models: latch reloads, each rising pad clock advances to the next bit.
  logic [7:0]  m_btn0, m_btn1;
  logic [3:0]  m_idx = 4'd0;
  logic        m_prev_clk = 1'b1;
  logic [11:0] s_btn;
  logic [4:0]  s_idx = 5'd0;
  logic        s_prev_clk = 1'b1;

  always @(posedge clk) begin
    m_prev_clk <= pad_clk;
    if (pad_latch) m_idx <= 4'd0;
    else if (pad_clk && !m_prev_clk && !m_idx[3]) m_idx <= m_idx + 4'd1;
    s_prev_clk <= pad_clk_s;
    if (pad_latch_s) s_idx <= 5'd0;
    else if (pad_clk_s && !s_prev_clk && s_idx < 5'd12) s_idx <= s_idx + 5'd1;
  end

  assign pad_data = pad_override ? 2'b00 :
                    m_idx[3] ? 2'b11 : {~m_btn1[m_idx[2:0]], ~m_btn0[m_idx[2:0]]};
  assign pad_data_s[0] = (s_idx < 5'd12) ? ~s_btn[s_idx[3:0]] : 1'b1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [15:0] exp_b;
    logic [15:0] exp_p;
  } vec_t;

  vec_t vecs [5];

  task automatic run_poll(input string tag, input logic [15:0] exp_b, input logic [15:0] exp_p);
    int   latch_len, pulses, valid_at, valid_cnt, stray;
    logic prev_clk;
    latch_len = 0; pulses = 0; valid_at = -1; valid_cnt = 0; stray = 0; prev_clk = 1'b1;
    @(negedge clk); poll_req = 1'b1;
    @(negedge clk); poll_req = 1'b0;
    check({tag, " latch_rise"}, 32'(pad_latch), 32'd1);
    check({tag, " busy_start"}, 32'(busy), 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (pad_latch) latch_len++;
      if (prev_clk && !pad_clk) pulses++;
      prev_clk = pad_clk;
      if (buttons_valid) begin
        valid_cnt++;
        valid_at = k;
        check({tag, " buttons"}, 32'(buttons), 32'(exp_b));
        check({tag, " pressed"}, 32'(pressed), 32'(exp_p));
      end else if (pressed != 16'h0) begin
        stray++;
      end
    end
    check({tag, " latch_len"}, latch_len, 32'd4);
    check({tag, " clk_pulses"}, pulses, 32'd7);
    check({tag, " valid_at"}, valid_at, 32'd32);
    check({tag, " valid_cnt"}, valid_cnt, 32'd1);
    check({tag, " stray_pressed"}, stray, 32'd0);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int act, rises, valids, prev_latch, pulses, valid_at;
    int rise_at [3];
    logic prev_clk;

    vecs[0] = '{(8'd1 << BTN_A) | (8'd1 << BTN_START), 8'd1 << BTN_RIGHT, 16'h8009, 16'h8009};
    vecs[1] = '{(8'd1 << BTN_A) | (8'd1 << BTN_B), 8'd1 << BTN_RIGHT, 16'h8003, 16'h0002};
    vecs[2] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[3] = '{8'hFF, 8'h5A, 16'h5AFF, 16'h5AFF};
    vecs[4] = '{8'hF0, 8'hA5, 16'hA5F0, 16'hA500};

    rst_n = 1'b0; ena = 1'b0; poll_req = 1'b0; poll_req_s = 1'b0; pad_override = 1'b1;
    m_btn0 = 8'h00; m_btn1 = 8'h00; s_btn = 12'h000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst pad_latch", 32'(pad_latch), 32'd0);
    check("rst pad_clk", 32'(pad_clk), 32'd1);
    check("rst buttons", 32'(buttons), 32'd0);
    check("rst pressed", 32'(pressed), 32'd0);
    check("rst valid", 32'(buttons_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst snes pad_clk", 32'(pad_clk_s), 32'd1);
    rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (pad_latch || !pad_clk || busy || buttons_valid) act++;
    end
    check("idle activity", act, 32'd0);
    pad_override = 1'b0;

    // Table-driven polls
    for (int i = 0; i < 5; i++) begin
      m_btn0 = vecs[i].p0;
      m_btn1 = vecs[i].p1;
      run_poll($sformatf("v%0d", i), vecs[i].exp_b, vecs[i].exp_p);
    end

    // Mid-transaction reset during CLK_HI of bit 4
    m_btn0 = 8'hFF; m_btn1 = 8'hFF;
    @(negedge clk); poll_req = 1'b1;
    @(negedge clk); poll_req = 1'b0;
    repeat (18) @(negedge clk);
    check("midrst pre clk_hi", 32'(pad_clk), 32'd1);
    check("midrst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst pad_clk", 32'(pad_clk), 32'd1);
    check("midrst pad_latch", 32'(pad_latch), 32'd0);
    check("midrst buttons", 32'(buttons), 32'd0);
    check("midrst valid", 32'(buttons_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    valids = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (buttons_valid) valids++;
    end
    check("midrst no valid", valids, 32'd0);

    // Auto-poll from reset with a dropped request while busy
    rst_n = 1'b0; ena = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rises = 0; prev_latch = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 71) poll_req = 1'b0;
      if (pad_latch && prev_latch == 0) begin
        if (rises < 3) rise_at[rises] = n;
        rises++;
      end
      prev_latch = int'(pad_latch);
      if (n == 70) begin
        check("auto busy at req", 32'(busy), 32'd1);
        poll_req = 1'b1;
      end
    end
    check("auto rise count", rises, 32'd3);
    check("auto rise0", rise_at[0], 32'd64);
    check("auto rise1", rise_at[1], 32'd128);
    check("auto rise2", rise_at[2], 32'd192);
    ena = 1'b0;
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    @(negedge clk);
    check("auto drained", 32'(busy), 32'd0);

    // SNES 12-bit pad
    s_btn = (12'd1 << 8) | (12'd1 << BTN_SNES_R);
    pulses = 0; valid_at = -1; prev_clk = 1'b1;
    @(negedge clk); poll_req_s = 1'b1;
    @(negedge clk); poll_req_s = 1'b0;
    check("snes latch_rise", 32'(pad_latch_s), 32'd1);
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (prev_clk && !pad_clk_s) pulses++;
      prev_clk = pad_clk_s;
      if (buttons_valid_s) begin
        valid_at = k;
        check("snes buttons", 32'(buttons_s), 32'h900);
        check("snes pressed", 32'(pressed_s), 32'h900);
      end
    end
    check("snes valid_at", valid_at, 32'd48);
    check("snes clk_pulses", pulses, 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
